// File: rtl/littlesoc_pkg.sv
// Shared definitions for the littlesoc SPI flash read path.
// Holds the responder state encoding, the SPI READ opcode, the frame length
// and a helper that turns the received serial byte stream into a
// little-endian bus word.
package littlesoc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2,
    GAP   = 2'd3
  } state_e;

  localparam logic [7:0]  SPI_CMD_READ   = 8'h03;
  localparam int unsigned SPI_FRAME_BITS = 64;

  // stream[31:24] is the first byte off the wire. It must land in the
  // least significant byte of the bus word.
  function automatic logic [31:0] stream_to_le_word(input logic [31:0] stream);
    return {stream[7:0], stream[15:8], stream[23:16], stream[31:24]};
  endfunction

endpackage

// File: rtl/spi_shifter.sv
// Single-bit SPI mode-0 frame engine. It contains the flash_clk divider,
// the 64-bit shift register and the bit counter.
// Ports:
//   clk, reset      system clock, synchronous active-high reset
//   i_start         load i_tx_word and begin a 64-bit frame (ignored while busy)
//   i_tx_word       command + 24-bit address, sent MSB first
//   o_rx_word       last 32 received bits, byte-swapped to little-endian
//   o_done          high during the final high-phase cycle of bit 63
//   o_busy          frame in progress; flash_cs_n is its inverse
//   o_sclk, o_cs_n, o_mosi, i_miso   flash pins
module spi_shifter
  import littlesoc_pkg::*;
#(
  parameter int unsigned CLK_DIV = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_start,
  input  logic [31:0] i_tx_word,
  output logic [31:0] o_rx_word,
  output logic        o_done,
  output logic        o_busy,
  output logic        o_sclk,
  output logic        o_cs_n,
  output logic        o_mosi,
  input  logic        i_miso
);

  localparam logic [15:0] DIV_LAST = 16'(CLK_DIV - 1);
  localparam logic [5:0]  BIT_LAST = 6'(SPI_FRAME_BITS - 1);

  logic        r_busy;
  logic        r_sclk;
  logic        r_mosi;
  logic [15:0] r_div_cnt;
  logic [5:0]  r_bit_cnt;
  logic [63:0] r_shift;
  logic        w_phase_end;
  logic        w_last_bit;

  assign w_phase_end = (r_div_cnt == DIV_LAST);
  assign w_last_bit  = (r_bit_cnt == BIT_LAST);

  // Frame engine: divider, phase toggle, shift on rising flash_clk, and
  // MOSI update on falling flash_clk. The upper half of r_shift drains out
  // on MOSI while MISO fills the lower half. Only the data bits
  // (bit_cnt[5] set) take MISO; the command/address bits shift in zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_busy    <= 1'b0;
      r_sclk    <= 1'b0;
      r_mosi    <= 1'b0;
      r_div_cnt <= 16'd0;
      r_bit_cnt <= 6'd0;
      r_shift   <= 64'd0;
    end else if (!r_busy) begin
      if (i_start) begin
        r_busy    <= 1'b1;
        r_sclk    <= 1'b0;
        r_div_cnt <= 16'd0;
        r_bit_cnt <= 6'd0;
        r_shift   <= {i_tx_word, 32'd0};
        r_mosi    <= i_tx_word[31];
      end
    end else if (!w_phase_end) begin
      r_div_cnt <= r_div_cnt + 16'd1;
    end else begin
      r_div_cnt <= 16'd0;
      if (!r_sclk) begin
        r_sclk  <= 1'b1;
        r_shift <= {r_shift[62:0], r_bit_cnt[5] & i_miso};
      end else if (w_last_bit) begin
        r_sclk <= 1'b0;
        r_busy <= 1'b0;
        r_mosi <= 1'b0;
      end else begin
        r_sclk    <= 1'b0;
        r_bit_cnt <= r_bit_cnt + 6'd1;
        // After k rising-edge shifts, bit 63 holds the next outgoing bit.
        r_mosi    <= r_shift[63];
      end
    end
  end

  assign o_done    = r_busy & r_sclk & w_phase_end & w_last_bit;
  assign o_busy    = r_busy;
  assign o_sclk    = r_sclk;
  assign o_cs_n    = ~r_busy;
  assign o_mosi    = r_mosi;
  assign o_rx_word = stream_to_le_word(r_shift[31:0]);

endmodule

// File: rtl/spi_flash_mem.sv
// Memory-bus responder that serves CPU data reads from SPI NOR flash using
// the single-bit READ (0x03) command. Writes are acknowledged and discarded.
// Ports:
//   clk, reset             system clock, synchronous active-high reset
//   mem_valid/mem_addr     request, address bits [23:2] select the word
//   mem_wstrb              nonzero marks a write (acked in one cycle)
//   mem_ready              one-cycle completion pulse
//   mem_rdata              read data, held until the next read completes
//   flash_*                SPI pins. wp_n and hold_n are tied high.
module spi_flash_mem
  import littlesoc_pkg::*;
#(
  parameter int unsigned CLK_DIV = 1,
  parameter int unsigned CS_HIGH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_valid,
  input  logic [31:0] mem_addr,
  input  logic [3:0]  mem_wstrb,
  output logic        mem_ready,
  output logic [31:0] mem_rdata,
  output logic        flash_cs_n,
  output logic        flash_clk,
  output logic        flash_mosi,
  input  logic        flash_miso,
  output logic        flash_wp_n,
  output logic        flash_hold_n
);

  localparam logic [15:0] CS_HIGH_C = 16'(CS_HIGH);

  state_e      r_state;
  state_e      w_state_nxt;
  logic        r_ready;
  logic [31:0] r_rdata;
  logic [15:0] r_gap_cnt;
  logic        w_ready_nxt;
  logic        w_rdata_load;
  logic        w_start;
  logic        w_gap_ok;
  logic        w_done;
  logic        w_busy;
  logic [31:0] w_rx_word;
  logic [31:0] w_tx_word;
  logic        w_unused_addr;

  assign w_tx_word     = {SPI_CMD_READ, mem_addr[23:2], 2'b00};
  assign w_unused_addr = ^{mem_addr[31:24], mem_addr[1:0]};
  // r_gap_cnt holds the count of completed cs_n-high cycles.
  assign w_gap_ok      = (r_gap_cnt >= CS_HIGH_C);

  spi_shifter #(
    .CLK_DIV (CLK_DIV)
  ) u_shifter (
    .clk       (clk),
    .reset     (reset),
    .i_start   (w_start),
    .i_tx_word (w_tx_word),
    .o_rx_word (w_rx_word),
    .o_done    (w_done),
    .o_busy    (w_busy),
    .o_sclk    (flash_clk),
    .o_cs_n    (flash_cs_n),
    .o_mosi    (flash_mosi),
    .i_miso    (flash_miso)
  );

  // Bus FSM state, registered response outputs and chip-select gap counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_ready   <= 1'b0;
      r_rdata   <= 32'd0;
      r_gap_cnt <= CS_HIGH_C;
    end else begin
      r_state <= w_state_nxt;
      r_ready <= w_ready_nxt;
      if (w_rdata_load) begin
        r_rdata <= w_rx_word;
      end
      if (w_busy) begin
        r_gap_cnt <= 16'd0;
      end else if (r_gap_cnt < CS_HIGH_C) begin
        r_gap_cnt <= r_gap_cnt + 16'd1;
      end
    end
  end

  // Next-state and response decode. While a ready pulse is out, IDLE does
  // not accept. This keeps a held mem_valid from producing back-to-back
  // ready pulses. The read result is captured in the final SHIFT cycle, so
  // it appears together with the DONE state.
  always_comb begin
    w_state_nxt  = r_state;
    w_ready_nxt  = 1'b0;
    w_rdata_load = 1'b0;
    w_start      = 1'b0;
    case (r_state)
      IDLE: begin
        if (mem_valid && w_gap_ok && !r_ready) begin
          if (|mem_wstrb) begin
            w_ready_nxt = 1'b1;
          end else begin
            w_start     = 1'b1;
            w_state_nxt = SHIFT;
          end
        end else begin
          w_state_nxt = IDLE;
        end
      end
      SHIFT: begin
        if (w_done) begin
          w_state_nxt  = DONE;
          w_rdata_load = 1'b1;
          w_ready_nxt  = mem_valid;
        end else begin
          w_state_nxt = SHIFT;
        end
      end
      DONE: begin
        w_state_nxt = GAP;
      end
      GAP: begin
        // The current GAP cycle is the one that completes the minimum.
        if (r_gap_cnt >= CS_HIGH_C - 16'd1) begin
          w_state_nxt = IDLE;
        end else begin
          w_state_nxt = GAP;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  assign mem_ready    = r_ready;
  assign mem_rdata    = r_rdata;
  assign flash_wp_n   = 1'b1;
  assign flash_hold_n = 1'b1;

endmodule

// File: tb/tb_spi_flash_mem.sv
module tb_spi_flash_mem;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // DUT A: CLK_DIV=1, CS_HIGH=2
  logic        a_reset, a_valid, a_ready, a_cs_n, a_sclk, a_mosi, a_miso, a_wp, a_hold;
  logic [31:0] a_addr, a_rdata;
  logic [3:0]  a_wstrb;
  // DUT B: CLK_DIV=3, CS_HIGH=2
  logic        b_reset, b_valid, b_ready, b_cs_n, b_sclk, b_mosi, b_miso, b_wp, b_hold;
  logic [31:0] b_addr, b_rdata;
  logic [3:0]  b_wstrb;

  int checks = 0;
  int errors = 0;

  spi_flash_mem #(.CLK_DIV(1), .CS_HIGH(2)) u_dut_a (
    .clk(clk), .reset(a_reset), .mem_valid(a_valid), .mem_addr(a_addr),
    .mem_wstrb(a_wstrb), .mem_ready(a_ready), .mem_rdata(a_rdata),
    .flash_cs_n(a_cs_n), .flash_clk(a_sclk), .flash_mosi(a_mosi),
    .flash_miso(a_miso), .flash_wp_n(a_wp), .flash_hold_n(a_hold)
  );

  spi_flash_mem #(.CLK_DIV(3), .CS_HIGH(2)) u_dut_b (
    .clk(clk), .reset(b_reset), .mem_valid(b_valid), .mem_addr(b_addr),
    .mem_wstrb(b_wstrb), .mem_ready(b_ready), .mem_rdata(b_rdata),
    .flash_cs_n(b_cs_n), .flash_clk(b_sclk), .flash_mosi(b_mosi),
    .flash_miso(b_miso), .flash_wp_n(b_wp), .flash_hold_n(b_hold)
  );

  // Flash contents: EF BE AD DE at 0x000100, elsewhere low address byte ^ 0x5A.
  function automatic logic [7:0] flash_byte(input logic [23:0] addr);
    case (addr)
      24'h000100: return 8'hEF;
      24'h000101: return 8'hBE;
      24'h000102: return 8'hAD;
      24'h000103: return 8'hDE;
      default:    return addr[7:0] ^ 8'h5A;
    endcase
  endfunction

  int cyc = 0;

  // Flash model A: MOSI captured on rising flash_clk, MISO driven on falling flash_clk.
  int          a_cnt = 0;
  logic [31:0] a_sr = 32'd0, a_hdr = 32'd0;
  logic [23:0] a_faddr = 24'd0;
  logic [7:0]  a_byte;
  int          a_k;
  initial a_miso = 1'b0;
  always @(posedge a_sclk or negedge a_sclk or posedge a_cs_n) begin
    if (a_cs_n) begin
      a_cnt = 0;
      a_miso = 1'b0;
    end else if (a_sclk) begin
      a_sr = {a_sr[30:0], a_mosi};
      a_cnt = a_cnt + 1;
      if (a_cnt == 32) begin
        a_hdr = a_sr;
        a_faddr = a_sr[23:0];
      end
    end else if (a_cnt >= 32 && a_cnt < 64) begin
      a_k = a_cnt - 32;
      a_byte = flash_byte(a_faddr + 24'(a_k / 8));
      a_miso = a_byte[7 - (a_k % 8)];
    end
  end

  // Flash model B, also records the flash_clk period in clk cycles.
  int          b_cnt = 0;
  logic [31:0] b_sr = 32'd0, b_hdr = 32'd0;
  logic [23:0] b_faddr = 24'd0;
  logic [7:0]  b_byte;
  int          b_k;
  int          b_last_rise = 0, b_period = 0;
  initial b_miso = 1'b0;
  always @(posedge b_sclk or negedge b_sclk or posedge b_cs_n) begin
    if (b_cs_n) begin
      b_cnt = 0;
      b_miso = 1'b0;
    end else if (b_sclk) begin
      b_period = cyc - b_last_rise;
      b_last_rise = cyc;
      b_sr = {b_sr[30:0], b_mosi};
      b_cnt = b_cnt + 1;
      if (b_cnt == 32) begin
        b_hdr = b_sr;
        b_faddr = b_sr[23:0];
      end
    end else if (b_cnt >= 32 && b_cnt < 64) begin
      b_k = b_cnt - 32;
      b_byte = flash_byte(b_faddr + 24'(b_k / 8));
      b_miso = b_byte[7 - (b_k % 8)];
    end
  end

  // Cycle counter, cs_n-low cycle count and last cs_n-high run length for A.
  int a_low_cnt = 0, a_high_run = 0, a_last_gap = 0;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!a_cs_n) a_low_cnt <= a_low_cnt + 1;
    if (a_cs_n) begin
      a_high_run <= a_high_run + 1;
    end else begin
      if (a_high_run != 0) a_last_gap <= a_high_run;
      a_high_run <= 0;
    end
  end

  // Issue one request on A and wait (bounded) for mem_ready.
  task automatic access_a(input logic [31:0] addr, input logic [3:0] wstrb,
                          output int lat, output logic [31:0] rd, output int low_cycles);
    int low0;
    repeat (4) @(negedge clk);
    low0 = a_low_cnt;
    a_addr = addr; a_wstrb = wstrb; a_valid = 1'b1;
    lat = 0;
    while (lat < 2000) begin
      @(negedge clk);
      lat++;
      if (a_ready) break;
    end
    rd = a_rdata;
    a_valid = 1'b0; a_wstrb = 4'd0;
    @(negedge clk);
    low_cycles = a_low_cnt - low0;
  endtask

  task automatic test_reset();
    a_reset = 1'b1; b_reset = 1'b1;
    a_valid = 1'b0; a_addr = 32'd0; a_wstrb = 4'd0;
    b_valid = 1'b0; b_addr = 32'd0; b_wstrb = 4'd0;
    repeat (3) @(negedge clk);
    checks++;
    if ({a_cs_n, a_sclk, a_mosi, a_ready, a_wp, a_hold} !== 6'b100011) begin
      errors++; $display("FAIL reset_pins_a got %b want 100011", {a_cs_n, a_sclk, a_mosi, a_ready, a_wp, a_hold});
    end
    checks++;
    if (a_rdata !== 32'd0) begin
      errors++; $display("FAIL reset_rdata_a got %h want 00000000", a_rdata);
    end
    checks++;
    if ({b_cs_n, b_sclk, b_mosi, b_ready, b_wp, b_hold, b_rdata} !== {6'b100011, 32'd0}) begin
      errors++; $display("FAIL reset_b got %b/%h want 100011/00000000", {b_cs_n, b_sclk, b_mosi, b_ready, b_wp, b_hold}, b_rdata);
    end
    a_reset = 1'b0; b_reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_read();
    int lat, low; logic [31:0] rd;
    access_a(32'h0000_0100, 4'd0, lat, rd, low);
    checks++;
    if (lat !== 129) begin errors++; $display("FAIL read_latency got %0d want 129", lat); end
    checks++;
    if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL read_data got %h want deadbeef", rd); end
    checks++;
    if (a_hdr !== 32'h03000100) begin errors++; $display("FAIL read_mosi got %h want 03000100", a_hdr); end
    checks++;
    if (low !== 128) begin errors++; $display("FAIL read_cs_low got %0d want 128", low); end
  endtask

  task automatic test_addr_mask();
    int lat, low; logic [31:0] rd;
    access_a(32'h0100_0102, 4'd0, lat, rd, low);
    checks++;
    if (a_hdr !== 32'h03000100) begin errors++; $display("FAIL mask_mosi got %h want 03000100", a_hdr); end
    checks++;
    if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL mask_data got %h want deadbeef", rd); end
  endtask

  task automatic test_write();
    int lat, low; logic [31:0] rd;
    access_a(32'h0000_0200, 4'b1111, lat, rd, low);
    checks++;
    if (lat !== 1) begin errors++; $display("FAIL write_latency got %0d want 1", lat); end
    checks++;
    if (low !== 0) begin errors++; $display("FAIL write_cs got %0d low cycles want 0", low); end
    checks++;
    if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL write_rdata got %h want deadbeef", rd); end
  endtask

  task automatic test_drop_valid();
    int readies = 0;
    repeat (4) @(negedge clk);
    a_addr = 32'h0000_0104; a_valid = 1'b1;
    repeat (30) @(negedge clk);
    a_valid = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (a_ready) readies++;
    end
    checks++;
    if (readies !== 0) begin errors++; $display("FAIL drop_valid_ready got %0d pulses want 0", readies); end
    checks++;
    if (a_hdr !== 32'h03000104 || a_cs_n !== 1'b1) begin
      errors++; $display("FAIL drop_valid_frame got %h cs_n %b want 03000104 cs_n 1", a_hdr, a_cs_n);
    end
  endtask

  task automatic test_reset_mid();
    int lat, low, wait_cyc, readies; logic [31:0] rd;
    repeat (4) @(negedge clk);
    a_addr = 32'h0000_0100; a_valid = 1'b1;
    wait_cyc = 0;
    while (a_cnt < 20 && wait_cyc < 500) begin @(negedge clk); wait_cyc++; end
    checks++;
    if (a_cnt < 20) begin errors++; $display("FAIL reset_mid_reach got bit %0d want 20", a_cnt); end
    a_valid = 1'b0; a_reset = 1'b1;
    @(negedge clk);
    checks++;
    if ({a_cs_n, a_sclk, a_ready} !== 3'b100) begin
      errors++; $display("FAIL reset_mid_pins got %b want 100", {a_cs_n, a_sclk, a_ready});
    end
    a_reset = 1'b0;
    readies = 0;
    for (int i = 0; i < 10; i++) begin @(negedge clk); if (a_ready) readies++; end
    checks++;
    if (readies !== 0) begin errors++; $display("FAIL reset_mid_ready got %0d want 0", readies); end
    access_a(32'h0000_0100, 4'd0, lat, rd, low);
    checks++;
    if (rd !== 32'hDEADBEEF || lat !== 129) begin
      errors++; $display("FAIL reset_mid_reread got %h lat %0d want deadbeef lat 129", rd, lat);
    end
  endtask

  task automatic test_back_to_back();
    int n; logic [31:0] rd1, rd2;
    repeat (4) @(negedge clk);
    a_addr = 32'h0000_0100; a_valid = 1'b1;
    n = 0;
    while (!a_ready && n < 2000) begin @(negedge clk); n++; end
    rd1 = a_rdata;
    a_addr = 32'h0000_0104;
    @(negedge clk);
    checks++;
    if (a_ready !== 1'b0) begin errors++; $display("FAIL b2b_ready_consecutive got %b want 0", a_ready); end
    n = 0;
    while (!a_ready && n < 2000) begin @(negedge clk); n++; end
    rd2 = a_rdata;
    a_valid = 1'b0;
    checks++;
    if (rd1 !== 32'hDEADBEEF) begin errors++; $display("FAIL b2b_first got %h want deadbeef", rd1); end
    checks++;
    if (rd2 !== 32'h5D5C5F5E) begin errors++; $display("FAIL b2b_second got %h want 5d5c5f5e", rd2); end
    checks++;
    if (a_hdr !== 32'h03000104) begin errors++; $display("FAIL b2b_mosi got %h want 03000104", a_hdr); end
    checks++;
    if (a_last_gap < 2) begin errors++; $display("FAIL b2b_cs_gap got %0d want >=2", a_last_gap); end
    @(negedge clk);
  endtask

  task automatic test_clk_div3();
    int lat; logic [31:0] rd;
    repeat (4) @(negedge clk);
    b_addr = 32'h0000_0100; b_wstrb = 4'd0; b_valid = 1'b1;
    lat = 0;
    while (lat < 2000) begin
      @(negedge clk);
      lat++;
      if (b_ready) break;
    end
    rd = b_rdata;
    b_valid = 1'b0;
    checks++;
    if (lat !== 385) begin errors++; $display("FAIL div3_latency got %0d want 385", lat); end
    checks++;
    if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL div3_data got %h want deadbeef", rd); end
    checks++;
    if (b_period !== 6) begin errors++; $display("FAIL div3_period got %0d want 6", b_period); end
    checks++;
    if (b_hdr !== 32'h03000100) begin errors++; $display("FAIL div3_mosi got %h want 03000100", b_hdr); end
  endtask

  initial begin
    test_reset();
    test_read();
    test_addr_mask();
    test_write();
    test_drop_valid();
    test_reset_mid();
    test_back_to_back();
    test_clk_div3();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
